golden_nonce_arbiter: RTL and testbench
=======================================

GOLDEN_NONCE_ARBITER -- requirements
Module: golden_nonce_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of hashcore result sources (2..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, result queue depth (power of 2, 2..16).
REQ-003 SHALL have port hash_clk, input, 1, the only clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1, synchronous clear of pending slots and queue.
REQ-006 SHALL have port gn_match, input, NUM_CORES, per-core golden_nonce_match level.
REQ-007 SHALL have port gn_nonce, input, 32*NUM_CORES, per-core golden nonce; core i occupies bits [32i+31:32i].
REQ-008 SHALL have port out_valid, output, 1, queue head valid.
REQ-009 SHALL have port out_nonce, output, 32, head nonce.
REQ-010 SHALL have port out_core, output, 4, head source core index.
REQ-011 SHALL have port out_ack, input, 1, host pop request.
REQ-012 SHALL have port fifo_level, output, 5, current queue occupancy.
REQ-013 SHALL have port overflow_count, output, 8, count of dropped results, saturating.

Function
REQ-014 SHALL register gn_match each cycle; a capture event for core i occurs when gn_match[i] is sampled 1 and its previous sample is 0.
REQ-015 SHALL, on a capture event, load gn_nonce[i] into pending slot i and set pending[i], visible after the same edge.
REQ-016 SHALL, on a capture event while pending[i] is already set and not granted that cycle, keep the old slot, drop the new nonce, and increment overflow_count.
REQ-017 SHALL grant at most one pending slot per cycle, only when the queue is not full at the start of the cycle.
REQ-018 SHALL select the grant round-robin: the first set pending bit at or above rr_ptr, wrapping modulo NUM_CORES.
REQ-019 SHALL, on a grant of core g, push {g, slot g} into the queue, clear pending[g], and set rr_ptr to (g+1) mod NUM_CORES.
REQ-020 SHALL, on a grant and capture of the same core in one cycle, push the old slot and leave pending set with the new nonce; no overflow.
REQ-021 SHALL drive out_valid = queue not empty; out_nonce/out_core show the head entry, held stable until popped.
REQ-022 SHALL pop the head on any edge with out_valid and out_ack both 1; out_ack with out_valid 0 is ignored.
REQ-023 SHALL not push when the queue is full, even if a pop occurs in the same cycle; the push happens the following cycle.
REQ-024 SHALL wrap queue pointers modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
REQ-025 SHALL give a latency of 2 edges from the first edge sampling gn_match[i]=1 to out_valid=1, with the queue empty and no competing pending.
REQ-026 SHALL saturate overflow_count at 255.
REQ-027 SHALL, on flush, clear pending, the queue, and rr_ptr on the next edge without clearing overflow_count or the edge registers; captures in the flush cycle are discarded.

Reset
REQ-028 SHALL asynchronously force pending=0, queue empty, rr_ptr=0, overflow_count=0, out_valid=0, out_nonce=0, out_core=0, and fifo_level=0.
REQ-029 SHALL reset the gn_match edge register to all ones, so a match already high at reset release is not captured.
REQ-030 SHALL treat reset asserted mid-operation as discarding all queued and pending results, with no partial output.

Structure
REQ-031 SHALL place NONCE_W=32, CORE_W=4, and the entry width (36) in shared package gn_arb_pkg.
REQ-032 SHALL instantiate one sub-module, gn_fifo (synchronous FIFO, width 36, depth FIFO_DEPTH, full/empty/level outputs).

Verification
REQ-033 SHALL verify single hit: core 2 match rises with nonce 0x1234ABCD -> out_valid after 2 edges, out_core=2, out_nonce=0x1234ABCD; out_ack pops and fifo_level returns to 0.
REQ-034 SHALL verify simultaneous hits: cores 0..3 rise together, no ack -> queue order 0,1,2,3, fifo_level 4; the next grant starts at core 0 (rr_ptr wrapped).
REQ-035 SHALL verify full queue: with 4 entries queued and no ack, core 1 rises twice (nonces 0xA, 0xB) -> 0xA held pending, 0xB dropped, overflow_count=1; one ack then 0xA enters one cycle after the pop.
REQ-036 SHALL verify saturation: 300 forced drops -> overflow_count=255.
REQ-037 SHALL verify reset and flush: reset mid-queue -> all outputs 0 asynchronously; gn_match held high across release -> no capture; flush with 3 entries -> level 0 with overflow_count unchanged.

Source files
------------

// File: rtl/gn_arb_pkg.sv
// Shared widths, the queue entry layout and a small round-robin helper
// used by the golden nonce arbiter and its result queue.
package gn_arb_pkg;

  localparam int NONCE_W = 32;
  localparam int CORE_W  = 4;
  localparam int ENTRY_W = NONCE_W + CORE_W;
  localparam int LEVEL_W = 5;
  localparam int OVF_W   = 8;
  localparam int OVF_MAX = 255;

  // One queued result: the source core index above its nonce.
  typedef struct packed {
    logic [CORE_W-1:0]  core;
    logic [NONCE_W-1:0] nonce;
  } gn_entry_t;

  // Index following idx in a ring of n cores.
  function automatic logic [CORE_W-1:0] next_core(input int idx, input int n);
    if (idx + 1 >= n) begin
      return '0;
    end
    return CORE_W'(idx + 1);
  endfunction

endpackage

// File: rtl/golden_nonce_arbiter_if.sv
// Host-facing result port of the golden nonce arbiter: head entry plus pop.
interface golden_nonce_arbiter_if;
  import gn_arb_pkg::*;

  logic               out_valid;
  logic [NONCE_W-1:0] out_nonce;
  logic [CORE_W-1:0]  out_core;
  logic               out_ack;

  modport master (
    output out_valid,
    output out_nonce,
    output out_core,
    input  out_ack
  );

  modport slave (
    input  out_valid,
    input  out_nonce,
    input  out_core,
    output out_ack
  );

endinterface

// File: rtl/gn_fifo.sv
// Synchronous first-word-fall-through FIFO holding granted results.
// Depth must be a power of two so the pointers wrap on their own.
module gn_fifo
  import gn_arb_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full      = (count_q == LEVEL_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push && !full && !clear;
  assign do_pop    = pop && !empty && !clear;
  assign head_data = mem_q[rd_ptr_q];
  assign level     = count_q;

  // Pointer and occupancy update; a clear empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + LEVEL_W'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - LEVEL_W'(1);
      end
    end
  end

  // Control state registers with asynchronous reset to an empty queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/golden_nonce_arbiter.sv
// Collects golden nonces from several hash cores: each rising match loads a
// per-core pending slot, one slot per cycle is granted round-robin into a
// result queue, and results that arrive while their slot is still occupied
// are dropped and counted.
module golden_nonce_arbiter
  import gn_arb_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         hash_clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_CORES-1:0]         gn_match,
  input  logic [NONCE_W*NUM_CORES-1:0] gn_nonce,
  golden_nonce_arbiter_if.master       out_if,
  output logic [LEVEL_W-1:0]           fifo_level,
  output logic [OVF_W-1:0]             overflow_count
);

  logic [NUM_CORES-1:0] match_q, match_d;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [NUM_CORES-1:0] capture;
  logic [NONCE_W-1:0]   slot_q [NUM_CORES];
  logic [NONCE_W-1:0]   slot_d [NUM_CORES];
  logic [CORE_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OVF_W-1:0]     ovf_q, ovf_d;

  logic                 grant_valid;
  logic [CORE_W-1:0]    grant_core;
  logic [NONCE_W-1:0]   grant_nonce;

  gn_entry_t            push_entry;
  gn_entry_t            head_entry;
  logic [ENTRY_W-1:0]   head_raw;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  assign match_d = gn_match;
  assign capture = gn_match & ~match_q;

  // Round-robin pick: first pending slot at or above rr_ptr, then wrap below it.
  // Nothing is granted into a queue that is full at the start of the cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_core  = '0;
    grant_nonce = '0;
    if (!fifo_full && !flush) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!grant_valid && pending_q[i] && (i >= int'(rr_ptr_q))) begin
          grant_valid = 1'b1;
          grant_core  = CORE_W'(i);
          grant_nonce = slot_q[i];
        end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!grant_valid && pending_q[i] && (i < int'(rr_ptr_q))) begin
          grant_valid = 1'b1;
          grant_core  = CORE_W'(i);
          grant_nonce = slot_q[i];
        end
      end
    end
  end

  // Slot capture, grant release, drop accounting and pointer advance.
  always_comb begin
    int   drops;
    logic granted;
    pending_d = pending_q;
    slot_d    = slot_q;
    rr_ptr_d  = rr_ptr_q;
    ovf_d     = ovf_q;
    drops     = 0;
    granted   = 1'b0;
    if (flush) begin
      pending_d = '0;
      rr_ptr_d  = '0;
    end else begin
      if (grant_valid) begin
        rr_ptr_d = next_core(int'(grant_core), NUM_CORES);
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        granted = grant_valid && (grant_core == CORE_W'(i));
        if (capture[i]) begin
          if (!pending_q[i] || granted) begin
            slot_d[i]    = gn_nonce[NONCE_W*i +: NONCE_W];
            pending_d[i] = 1'b1;
          end else begin
            drops = drops + 1;
          end
        end else if (granted) begin
          pending_d[i] = 1'b0;
        end
      end
      if (int'(ovf_q) + drops > OVF_MAX) begin
        ovf_d = OVF_W'(OVF_MAX);
      end else begin
        ovf_d = OVF_W'(int'(ovf_q) + drops);
      end
    end
  end

  // Arbiter state; the edge register resets high so a match that is already
  // asserted when reset releases is not mistaken for a new result.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      match_q   <= '1;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      ovf_q     <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      match_q   <= match_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      ovf_q     <= ovf_d;
      slot_q    <= slot_d;
    end
  end

  assign push_entry.core  = grant_core;
  assign push_entry.nonce = grant_nonce;
  assign fifo_pop         = out_if.out_ack && !fifo_empty;

  gn_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (hash_clk),
    .rst       (reset),
    .clear     (flush),
    .push      (grant_valid),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign head_entry       = gn_entry_t'(head_raw);
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_nonce = fifo_empty ? '0 : head_entry.nonce;
  assign out_if.out_core  = fifo_empty ? '0 : head_entry.core;
  assign overflow_count   = ovf_q;

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Directed bench for the golden nonce arbiter; expected queue entries are
// pushed to a scoreboard as hits are driven and popped as the host acks.
module tb_golden_nonce_arbiter;
  import gn_arb_pkg::*;

  localparam int NC = 4;
  localparam int FD = 4;

  logic              hash_clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [NC-1:0]     gn_match;
  logic [32*NC-1:0]  gn_nonce;
  logic [4:0]        fifo_level;
  logic [7:0]        overflow_count;

  int checks = 0;
  int errors = 0;
  gn_entry_t expq[$];

  golden_nonce_arbiter_if gn_if ();

  golden_nonce_arbiter #(
    .NUM_CORES  (NC),
    .FIFO_DEPTH (FD)
  ) dut (
    .hash_clk       (hash_clk),
    .reset          (reset),
    .flush          (flush),
    .gn_match       (gn_match),
    .gn_nonce       (gn_nonce),
    .out_if         (gn_if),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hash_clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] match);
    gn_match = match;
  endtask

  task automatic setNonce(input int core, input logic [31:0] val);
    gn_nonce[32*core +: 32] = val;
  endtask

  task automatic expectEntry(input int core, input logic [31:0] nonce);
    gn_entry_t e;
    e.core  = 4'(core);
    e.nonce = nonce;
    expq.push_back(e);
  endtask

  task automatic popAndCheck(input string tag);
    gn_entry_t e;
    checkOutput({tag, ".valid"}, {31'd0, gn_if.out_valid}, 32'd1);
    checks++;
    assert (expq.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s.sb observed=empty expected=entry", tag);
    end
    if (expq.size() != 0) begin
      e = expq.pop_front();
      checkOutput({tag, ".core"}, {28'd0, gn_if.out_core}, {28'd0, e.core});
      checkOutput({tag, ".nonce"}, gn_if.out_nonce, e.nonce);
    end
    gn_if.out_ack = 1'b1;
    tick(1);
    gn_if.out_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    gn_match      = '0;
    gn_nonce      = '0;
    gn_if.out_ack = 1'b0;
    tick(2);
    checkOutput("rst.valid", {31'd0, gn_if.out_valid}, 32'd0);
    checkOutput("rst.nonce", gn_if.out_nonce, 32'd0);
    checkOutput("rst.core", {28'd0, gn_if.out_core}, 32'd0);
    checkOutput("rst.level", 32'(fifo_level), 32'd0);
    checkOutput("rst.ovf", 32'(overflow_count), 32'd0);
    reset = 1'b0;
    tick(1);

    // single hit on core 2, two-edge latency
    setNonce(2, 32'h1234ABCD);
    applyStimulus(4'b0100);
    expectEntry(2, 32'h1234ABCD);
    tick(1);
    checkOutput("single.lat1", {31'd0, gn_if.out_valid}, 32'd0);
    tick(1);
    checkOutput("single.lat2", {31'd0, gn_if.out_valid}, 32'd1);
    checkOutput("single.level", 32'(fifo_level), 32'd1);
    popAndCheck("single.pop");
    checkOutput("single.level0", 32'(fifo_level), 32'd0);
    checkOutput("single.valid0", {31'd0, gn_if.out_valid}, 32'd0);
    applyStimulus(4'b0000);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;

    // simultaneous hits on all cores, then rr wrap check with cores 3 and 0
    for (int i = 0; i < NC; i++) begin
      setNonce(i, 32'hB000_0000 + 32'(i));
      expectEntry(i, 32'hB000_0000 + 32'(i));
    end
    applyStimulus(4'b1111);
    tick(5);
    checkOutput("simul.level", 32'(fifo_level), 32'd4);
    applyStimulus(4'b0000);
    tick(1);
    setNonce(0, 32'h0000_00C0);
    setNonce(3, 32'h0000_00C3);
    applyStimulus(4'b1001);
    expectEntry(0, 32'h0000_00C0);
    expectEntry(3, 32'h0000_00C3);
    tick(2);
    checkOutput("simul.full_hold", 32'(fifo_level), 32'd4);
    applyStimulus(4'b0000);
    for (int i = 0; i < 4; i++) begin
      popAndCheck($sformatf("simul.pop%0d", i));
    end
    checkOutput("simul.level2", 32'(fifo_level), 32'd2);
    popAndCheck("wrap.pop0");
    popAndCheck("wrap.pop3");
    checkOutput("wrap.level0", 32'(fifo_level), 32'd0);

    // full queue: core 1 pends 0xA, drops 0xB
    for (int i = 0; i < NC; i++) begin
      setNonce(i, 32'hD0 + 32'(i));
      expectEntry(i, 32'hD0 + 32'(i));
    end
    applyStimulus(4'b1111);
    tick(6);
    applyStimulus(4'b0000);
    tick(1);
    checkOutput("full.level", 32'(fifo_level), 32'd4);
    setNonce(1, 32'h0000_000A);
    applyStimulus(4'b0010);
    expectEntry(1, 32'h0000_000A);
    tick(1);
    applyStimulus(4'b0000);
    tick(1);
    setNonce(1, 32'h0000_000B);
    applyStimulus(4'b0010);
    tick(1);
    applyStimulus(4'b0000);
    checkOutput("full.ovf", 32'(overflow_count), 32'd1);
    checkOutput("full.level4", 32'(fifo_level), 32'd4);
    popAndCheck("full.pop0");
    checkOutput("full.after_pop", 32'(fifo_level), 32'd3);
    tick(1);
    checkOutput("full.refill", 32'(fifo_level), 32'd4);
    for (int i = 1; i < 5; i++) begin
      popAndCheck($sformatf("full.drain%0d", i));
    end
    checkOutput("full.empty", 32'(fifo_level), 32'd0);

    // saturation: rr_ptr sits at 2 so the fill order is 2,3,0,1
    for (int i = 0; i < NC; i++) begin
      setNonce(i, 32'hE0 + 32'(i));
    end
    expectEntry(2, 32'hE2);
    expectEntry(3, 32'hE3);
    expectEntry(0, 32'hE0);
    expectEntry(1, 32'hE1);
    applyStimulus(4'b1111);
    tick(6);
    applyStimulus(4'b0000);
    tick(1);
    for (int i = 0; i < NC; i++) begin
      setNonce(i, 32'hF0 + 32'(i));
    end
    applyStimulus(4'b1111);
    tick(1);
    applyStimulus(4'b0000);
    tick(1);
    for (int t = 0; t < 63; t++) begin
      applyStimulus(4'b1111);
      tick(1);
      applyStimulus(4'b0000);
      tick(1);
    end
    checkOutput("sat.ovf253", 32'(overflow_count), 32'd253);
    for (int t = 0; t < 12; t++) begin
      applyStimulus(4'b1111);
      tick(1);
      applyStimulus(4'b0000);
      tick(1);
      if (t == 0) begin
        checkOutput("sat.cross", 32'(overflow_count), 32'd255);
      end
    end
    checkOutput("sat.ovf255", 32'(overflow_count), 32'd255);
    checkOutput("sat.level", 32'(fifo_level), 32'd4);
    checkOutput("sat.head_core", {28'd0, gn_if.out_core}, 32'd2);
    checkOutput("sat.head_nonce", gn_if.out_nonce, 32'hE2);

    // asynchronous reset mid-queue, match held high across release
    reset = 1'b1;
    #2;
    checkOutput("arst.valid", {31'd0, gn_if.out_valid}, 32'd0);
    checkOutput("arst.nonce", gn_if.out_nonce, 32'd0);
    checkOutput("arst.core", {28'd0, gn_if.out_core}, 32'd0);
    checkOutput("arst.level", 32'(fifo_level), 32'd0);
    checkOutput("arst.ovf", 32'(overflow_count), 32'd0);
    expq.delete();
    setNonce(2, 32'h0000_0099);
    applyStimulus(4'b0100);
    tick(2);
    reset = 1'b0;
    tick(3);
    checkOutput("release.level", 32'(fifo_level), 32'd0);
    checkOutput("release.valid", {31'd0, gn_if.out_valid}, 32'd0);
    applyStimulus(4'b0000);
    tick(1);

    // flush with three entries queued and a capture in the flush cycle
    for (int i = 0; i < NC; i++) begin
      setNonce(i, 32'h50 + 32'(i));
      expectEntry(i, 32'h50 + 32'(i));
    end
    applyStimulus(4'b1111);
    tick(6);
    applyStimulus(4'b0000);
    tick(1);
    setNonce(0, 32'h60);
    applyStimulus(4'b0001);
    expectEntry(0, 32'h60);
    tick(1);
    applyStimulus(4'b0000);
    tick(1);
    applyStimulus(4'b0001);
    tick(1);
    applyStimulus(4'b0000);
    popAndCheck("flush.pop0");
    popAndCheck("flush.pop1");
    checkOutput("flush.pre_level", 32'(fifo_level), 32'd3);
    checkOutput("flush.pre_ovf", 32'(overflow_count), 32'd1);
    setNonce(2, 32'h77);
    applyStimulus(4'b0100);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checkOutput("flush.level", 32'(fifo_level), 32'd0);
    checkOutput("flush.valid", {31'd0, gn_if.out_valid}, 32'd0);
    checkOutput("flush.ovf", 32'(overflow_count), 32'd1);
    tick(3);
    checkOutput("flush.discard", 32'(fifo_level), 32'd0);
    expq.delete();
    applyStimulus(4'b0000);
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
